rr_arb_2to1: RTL
================

Name: rr_arb_2to1

Overview:
- Two-channel round-robin arbiter with a registered output slot.
- Sits directly upstream of the 8-bit 2:1 data mux: it selects one of two producers per transfer and drives the mux select (out_src) together with the registered winning data.
- Valid/ready handshake on both inputs and on the output.
- Per-channel saturating grant counters support debug and fairness checks.

Parameters:
- WIDTH, 8, data width of each channel and of out_data.
- CNT_W, 8, width of each saturating grant counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in0_valid  input  1  channel 0 has data
- in0_data  input  WIDTH  channel 0 payload
- in0_ready  output  1  channel 0 transfer accepted this cycle
- in1_valid  input  1  channel 1 has data
- in1_data  input  WIDTH  channel 1 payload
- in1_ready  output  1  channel 1 transfer accepted this cycle
- out_valid  output  1  output slot holds data
- out_data  output  WIDTH  registered winning payload
- out_src  output  1  channel that produced out_data; drives downstream mux select (0 = ch0/a, 1 = ch1/b)
- out_ready  input  1  consumer accepts out_data
- gnt_cnt0  output  CNT_W  saturating count of ch0 grants
- gnt_cnt1  output  CNT_W  saturating count of ch1 grants

Behaviour:
- Reset: clk and rst only; rst is asynchronous and active-high. While rst is high:
  - out_valid=0, out_data=0, out_src=0;
  - priority pointer prio=0 (ch0 favoured);
  - gnt_cnt0=gnt_cnt1=0;
  - in0_ready=in1_ready=0.
- Reset mid-operation: any held output is discarded. Nothing is accepted until the first rising edge after rst deasserts.
- Slot load enable: load = !out_valid | out_ready. The slot can refill in the same cycle it drains, giving full throughput of one transfer per cycle.
- Arbitration (combinational, evaluated only when load=1):
  - only in0_valid -> grant ch0;
  - only in1_valid -> grant ch1;
  - both valid -> grant channel prio;
  - neither -> no grant.
- Handshake outputs: inX_ready = load & grantX. At most one inX_ready is high in any cycle. Ready may depend combinationally on valid; valid must not depend on ready.
- On a grant at a clock edge:
  - out_data <= granted data;
  - out_src <= granted index;
  - out_valid <= 1;
  - prio <= ~granted index;
  - granted counter increments, saturating at 2^CNT_W-1.
- No grant with load=1: out_valid <= 0. out_data and out_src hold their last values.
- Stall (out_valid=1 and out_ready=0): out_data, out_src and out_valid are held. Both inX_ready=0. prio and counters are unchanged.
- Latency: one cycle from the input handshake to out_valid.
- Fairness: with both channels continuously valid and out_ready=1, grants strictly alternate 0,1,0,1... No channel waits more than one grant while the other is served.
- Input data is sampled only on its handshake cycle. Producers must hold valid and data until ready; the block does not check this.
- Counters: saturate and never wrap. They are cleared only by rst.

Test Plan:
- Reset: assert rst mid-stream with out_valid=1 -> out_valid, out_data, out_src, gnt_cnt0 and gnt_cnt1 go to 0 immediately, without waiting for a clock edge. After release, the first simultaneous request is granted to ch0.
- Single channel: in1_valid=1 with data 8'hA5, in0_valid=0, out_ready=1 -> in1_ready=1. Next cycle out_valid=1, out_data=8'hA5, out_src=1, gnt_cnt1=1.
- Contention: both valid continuously, in0_data=8'h11, in1_data=8'h22, out_ready=1 -> out_data sequence 11,22,11,22 with out_src 0,1,0,1. After 4 cycles gnt_cnt0=2 and gnt_cnt1=2.
- Backpressure: the slot holds 8'h11 and out_ready=0 for 3 cycles -> out_data stays 8'h11, both readies are 0 and prio is unchanged. When out_ready returns to 1, the same cycle grants the next channel (ch1, 8'h22).
- Simultaneous drain and refill: out_valid=1, out_ready=1, in0_valid=1 with 8'h3C -> in0_ready=1 that cycle. Next cycle out_data=8'h3C with no bubble.
- Saturation: with CNT_W=2, perform 5 ch0-only grants -> gnt_cnt0 sequence 1,2,3,3,3, and gnt_cnt1 stays 0.

Source files
------------

// File: rtl/rr_arb_2to1_if.sv
// Handshake bundle for the 2:1 round-robin arbiter: two producer channels,
// one registered output slot and the per-channel grant counters.
interface rr_arb_2to1_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             in0_valid;
  logic [WIDTH-1:0] in0_data;
  logic             in0_ready;
  logic             in1_valid;
  logic [WIDTH-1:0] in1_data;
  logic             in1_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_src;
  logic             out_ready;
  logic [CNT_W-1:0] gnt_cnt0;
  logic [CNT_W-1:0] gnt_cnt1;

  // Producers and consumer side.
  modport master (
    output in0_valid, in0_data, in1_valid, in1_data, out_ready,
    input  in0_ready, in1_ready, out_valid, out_data, out_src,
           gnt_cnt0, gnt_cnt1
  );

  // Arbiter side.
  modport slave (
    input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
    output in0_ready, in1_ready, out_valid, out_data, out_src,
           gnt_cnt0, gnt_cnt1
  );
endinterface

// File: rtl/rr_arb_2to1.sv
// Two-channel round-robin arbiter feeding a registered output slot; out_src
// doubles as the select for the downstream 2:1 data mux.
module rr_arb_2to1 #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  rr_arb_2to1_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_src_q;
  logic             prio;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
  logic             load;
  logic             gnt0;
  logic             gnt1;

  // Slot may refill in the same cycle it drains.
  assign load = !out_valid_q || bus.out_ready;

  // Ready is masked during reset so nothing is taken before release.
  assign gnt0 = !rst && load && bus.in0_valid && (!bus.in1_valid || !prio);
  assign gnt1 = !rst && load && bus.in1_valid && (!bus.in0_valid ||  prio);

  assign bus.in0_ready = gnt0;
  assign bus.in1_ready = gnt1;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.gnt_cnt0  = cnt0;
  assign bus.gnt_cnt1  = cnt1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= {WIDTH{1'b0}};
      out_src_q   <= 1'b0;
      prio        <= 1'b0;
    end else if (gnt0 || gnt1) begin
      out_valid_q <= 1'b1;
      out_data_q  <= gnt1 ? bus.in1_data : bus.in0_data;
      out_src_q   <= gnt1;
      prio        <= !gnt1;
    end else if (load) begin
      out_valid_q <= 1'b0;
    end
  end

  // Grant counters stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (gnt0 && cnt0 != CNT_MAX) cnt0 <= cnt0 + 1'b1;
      if (gnt1 && cnt1 != CNT_MAX) cnt1 <= cnt1 + 1'b1;
    end
  end
endmodule
